// File: rtl/ldpc_encoder.sv
// ldpc_encoder: systematic quasi-cyclic parity encoder.
// Forwards K_WORDS information words unchanged, then appends P_WORDS parity
// words. Parity j is the XOR of every information word i rotated left by
// (i*(2j+1)) mod WIDTH.
//
// Ports:
//   i_clock      rising-edge clock
//   i_reset      synchronous active-high reset
//   i_in_data    information word
//   i_in_valid   i_in_data valid
//   o_in_ready   encoder accepts a word (transfer = valid && ready at an edge)
//   o_out_data   codeword word (information, then parity)
//   o_out_valid  o_out_data valid, no backpressure
//   o_out_last   high with the final parity word of each codeword
module ldpc_encoder #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned K_WORDS = 4,
  parameter int unsigned P_WORDS = 2
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid,
  output logic             o_out_last
);

  localparam int unsigned CNT_W = (K_WORDS > 1) ? $clog2(K_WORDS) : 1;
  localparam int unsigned PAR_W = (P_WORDS > 1) ? $clog2(P_WORDS) : 1;

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_PARITY  = 1'b1
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   info_cnt_q;
  logic [PAR_W-1:0]   par_cnt_q;
  logic [WIDTH-1:0]   acc_q    [P_WORDS];
  logic [WIDTH-1:0]   acc_d    [P_WORDS];
  logic               in_ready_q;
  logic [WIDTH-1:0]   out_data_q;
  logic               out_valid_q;
  logic               out_last_q;
  logic               xfer_c;

  assign o_in_ready  = in_ready_q;
  assign o_out_data  = out_data_q;
  assign o_out_valid = out_valid_q;
  assign o_out_last  = out_last_q;

  assign xfer_c = i_in_valid && in_ready_q;

  // Left circular rotate: the upper half of the shifted double word wraps
  // the bits pushed out of the top back into the bottom.
  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x,
                                            input int unsigned     s);
    logic [2*WIDTH-1:0] dbl;
    dbl = {x, x} << s;
    return dbl[2*WIDTH-1:WIDTH];
  endfunction

  // Accumulators with the current input word folded in.
  always_comb begin
    for (int unsigned j = 0; j < P_WORDS; j++) begin
      acc_d[j] = acc_q[j] ^
                 rotl(i_in_data, (32'(info_cnt_q) * (2 * j + 1)) % WIDTH);
    end
  end

  // Control FSM, counters, accumulators and registered outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= S_COLLECT;
      info_cnt_q  <= '0;
      par_cnt_q   <= '0;
      in_ready_q  <= 1'b1;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int unsigned j = 0; j < P_WORDS; j++) acc_q[j] <= '0;
    end else begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      case (state_q)
        S_COLLECT: begin
          if (xfer_c) begin
            out_data_q  <= i_in_data;
            out_valid_q <= 1'b1;
            for (int unsigned j = 0; j < P_WORDS; j++) acc_q[j] <= acc_d[j];
            if (info_cnt_q == CNT_W'(K_WORDS - 1)) begin
              info_cnt_q <= '0;
              in_ready_q <= 1'b0;
              state_q    <= S_PARITY;
            end else begin
              info_cnt_q <= info_cnt_q + CNT_W'(1);
            end
          end
        end
        S_PARITY: begin
          out_data_q  <= acc_q[par_cnt_q];
          out_valid_q <= 1'b1;
          if (par_cnt_q == PAR_W'(P_WORDS - 1)) begin
            // Final parity word: close the codeword and re-open input.
            out_last_q <= 1'b1;
            par_cnt_q  <= '0;
            in_ready_q <= 1'b1;
            state_q    <= S_COLLECT;
            for (int unsigned j = 0; j < P_WORDS; j++) acc_q[j] <= '0;
          end else begin
            par_cnt_q <= par_cnt_q + PAR_W'(1);
          end
        end
        default: begin
          state_q    <= S_COLLECT;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ldpc_encoder.sv
// Self-checking bench for ldpc_encoder: a reference model predicts every
// output word into a queue at the clock edge it is produced, and the monitor
// pops and compares on the falling edge.
module tb_ldpc_encoder;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned K     = 4;
  localparam int unsigned P     = 2;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             vin;
  logic             rdy;
  logic [WIDTH-1:0] dout;
  logic             vout;
  logic             lout;

  ldpc_encoder #(.WIDTH(WIDTH), .K_WORDS(K), .P_WORDS(P)) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_in_data   (din),
    .i_in_valid  (vin),
    .o_in_ready  (rdy),
    .o_out_data  (dout),
    .o_out_valid (vout),
    .o_out_last  (lout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] out_hist[$];
  int               checks = 0;
  int               errors = 0;
  bit               chk_en = 1'b0;
  int               out_cnt = 0;
  int               ready_low_cnt = 0;

  // Reference model state.
  bit               m_ready = 1'b1;
  bit               m_par_st = 1'b0;
  int               m_cnt = 0;
  int               m_par = 0;
  logic [WIDTH-1:0] m_acc[P];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bitwise rotate: bit b moves to position (b+s) mod WIDTH.
  function automatic logic [WIDTH-1:0] rotl_ref(input logic [WIDTH-1:0] x, input int s);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int b = 0; b < WIDTH; b++) r[(b + s) % WIDTH] = x[b];
    return r;
  endfunction

  // Reference model, evaluated at each rising edge.
  initial begin
    for (int j = 0; j < P; j++) m_acc[j] = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_ready  = 1'b1;
        m_par_st = 1'b0;
        m_cnt    = 0;
        m_par    = 0;
        for (int j = 0; j < P; j++) m_acc[j] = '0;
      end else if (m_par_st) begin
        exp_q.push_back('{data: m_acc[m_par], last: (m_par == P - 1)});
        if (m_par == P - 1) begin
          for (int j = 0; j < P; j++) m_acc[j] = '0;
          m_par    = 0;
          m_par_st = 1'b0;
          m_ready  = 1'b1;
        end else begin
          m_par++;
        end
      end else if (vin && m_ready) begin
        exp_q.push_back('{data: din, last: 1'b0});
        for (int j = 0; j < P; j++)
          m_acc[j] = m_acc[j] ^ rotl_ref(din, (m_cnt * (2 * j + 1)) % WIDTH);
        if (m_cnt == K - 1) begin
          m_cnt    = 0;
          m_par_st = 1'b1;
          m_ready  = 1'b0;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  // Monitor: compares outputs against the model on each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("ready", 32'(rdy), 32'(m_ready));
        if (!rdy) ready_low_cnt++;
        if (vout) begin
          out_cnt++;
          out_hist.push_back(dout);
          if (exp_q.size() == 0) begin
            chk("unexpected_valid", 32'(1), 32'(0));
          end else begin
            e = exp_q.pop_front();
            chk("data", 32'(dout), 32'(e.data));
            chk("last", 32'(lout), 32'(e.last));
          end
        end else begin
          chk("last_idle", 32'(lout), 32'(0));
          if (exp_q.size() != 0) begin
            chk("missing_word", 32'(0), 32'(exp_q.size()));
            exp_q.delete();
          end
        end
      end
    end
  end

  task automatic send_cw(input logic [WIDTH-1:0] w0, input logic [WIDTH-1:0] w1,
                         input logic [WIDTH-1:0] w2, input logic [WIDTH-1:0] w3);
    logic [WIDTH-1:0] w[4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vin = 1'b1;
      din = w[i];
    end
    @(negedge clk);
    vin = 1'b0;
    repeat (P + 2) @(negedge clk);
  endtask

  task automatic chk_par(input string tag, input logic [WIDTH-1:0] p0, input logic [WIDTH-1:0] p1);
    int n;
    n = out_hist.size();
    if (n < 2) begin
      chk({tag, "_hist"}, 32'(n), 32'(2));
    end else begin
      chk({tag, "_p0"}, 32'(out_hist[n - 2]), 32'(p0));
      chk({tag, "_p1"}, 32'(out_hist[n - 1]), 32'(p1));
    end
  endtask

  initial begin
    int c0;
    int r0;
    logic [WIDTH-1:0] k;
    rst = 1'b1;
    vin = 1'b0;
    din = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(vout), 32'(0));
    chk("rst_last",  32'(lout), 32'(0));
    chk("rst_data",  32'(dout), 32'(0));
    chk("rst_ready", 32'(rdy),  32'(1));
    rst = 1'b0;
    chk_en = 1'b1;

    // Idle
    c0 = out_cnt;
    repeat (100) @(negedge clk);
    chk("idle_valid_pulses", 32'(out_cnt - c0), 32'(0));

    // Unit impulse
    c0 = out_cnt;
    send_cw(16'h0001, 16'h0000, 16'h0000, 16'h0000);
    chk("impulse_count", 32'(out_cnt - c0), 32'(6));
    chk_par("impulse", 16'h0001, 16'h0001);

    // Rotation, all ones
    send_cw(16'h0001, 16'h0001, 16'h0001, 16'h0001);
    chk_par("ones", 16'h000F, 16'h0249);

    // Rotation wrap
    send_cw(16'h0000, 16'h8000, 16'h0000, 16'h0000);
    chk_par("wrap1", 16'h0001, 16'h0004);
    send_cw(16'h8000, 16'h0000, 16'h0000, 16'h0000);
    chk_par("wrap0", 16'h8000, 16'h8000);

    // Continuous valid with an incrementing counter over 3 codewords
    c0 = out_cnt;
    r0 = ready_low_cnt;
    k  = '0;
    repeat (18) begin
      @(negedge clk);
      vin = 1'b1;
      din = k;
      k   = k + 16'd1;
    end
    @(negedge clk);
    vin = 1'b0;
    repeat (4) @(negedge clk);
    chk("bp_out_count",   32'(out_cnt - c0), 32'(18));
    chk("bp_ready_low",   32'(ready_low_cnt - r0), 32'(6));

    // Reset mid-codeword
    c0 = out_cnt;
    @(negedge clk);
    vin = 1'b1;
    din = 16'h1234;
    @(negedge clk);
    din = 16'h5678;
    @(negedge clk);
    vin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_idle_count", 32'(out_cnt - c0), 32'(2));
    send_cw(16'h0001, 16'h0000, 16'h0000, 16'h0000);
    chk("rstmid_count", 32'(out_cnt - c0), 32'(8));
    chk_par("rstmid", 16'h0001, 16'h0001);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
